t01_ai_mmu_sequencer: RTL and testbench
=======================================

Name: t01_ai_mmu_sequencer

Overview:
- Initiator/driver for the t01_ai_MMU 32x32 layer engine; runs one full 4-layer inference (4->32->32->32->1) per request.
- Latches the 4 board features and sequences layer_sel 0..3.
- Streams activations into the MMU and collects its ReLU results into ping-pong buffers, requantizing them to 8 bits for the next layer.
- Returns the final 18-bit score to the colorTetris placement evaluator.

Parameters:
- N_FEAT, 4, number of layer-0 input features.
- N_HID, 32, hidden-layer width; also the input count of layers 1-3.
- RQ_SHIFT, 4, right shift applied to MMU results before 8-bit saturation.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  1  start-inference pulse; accepted only in IDLE.
- feat_in  in  32  four signed 8-bit features; entry k = feat_in[8k+7:8k]; sampled on accepted req.
- busy  out  1  high from the cycle after req acceptance until score_valid.
- score_valid  out  1  one-cycle pulse; score is valid.
- score  out  18  final layer-3 result, unmodified MMU res_out; held until next score_valid.
- mmu_start  out  1  one-cycle start pulse to MMU.
- mmu_layer_sel  out  2  layer select; stable from mmu_start through mmu_done.
- mmu_act_valid  out  1  activation strobe.
- mmu_act_in  out  8  signed activation.
- mmu_res_valid  in  1  MMU result strobe.
- mmu_res_out  in  18  MMU result; ReLU'd, so never negative.
- mmu_done  in  1  MMU last-result pulse; coincides with the final res_valid.

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous, active-low.
- Reset values: state=IDLE, layer=0, bank=0, all counters 0. Outputs busy, score_valid, score, mmu_start, mmu_layer_sel, mmu_act_valid, mmu_act_in all 0. Buffer contents don't-care.
- Storage:
  - feature register, 4x8;
  - two activation banks, 32x8 each;
  - bank bit selects the read bank; the write bank is ~bank.
- States: IDLE, START, FEED, COLLECT, FINISH.
- IDLE:
  - req=1 latches feat_in, sets layer=0, goes to START.
  - req is ignored in every other state; busy masks it.
- START:
  - mmu_start=1 for exactly this one cycle.
  - mmu_layer_sel=layer from here until layer changes.
  - feed index i=0; go to FEED.
- FEED:
  - mmu_act_valid=1 on every FEED cycle, back-to-back with no gaps.
  - mmu_act_in = feature[i] when layer=0, else readbank[i]. Entry order matches MMU input index order.
  - n = N_FEAT for layer 0, else N_HID.
  - After the cycle with i=n-1, go to COLLECT. mmu_act_valid drops to 0 that edge.
  - First act_valid is the cycle immediately after the mmu_start cycle.
- COLLECT:
  - Result counter r starts at 0.
  - Each mmu_res_valid writes rq(mmu_res_out) to writebank[r], then r++.
  - rq(x) = (x >> RQ_SHIFT) > 127 ? 8'd127 : (x >> RQ_SHIFT)[7:0]. Result is always 0..127.
  - On mmu_done: the final res_valid of the same cycle is written first.
    - If layer<3: layer++, bank flips, go to START. START is the cycle after done; the MMU is idle by then.
    - If layer=3: score <= mmu_res_out (raw 18-bit), go to FINISH.
  - mmu_res_valid/mmu_done seen in IDLE, START or FEED are ignored.
  - r wraps mod 32; writes beyond 32 are not expected.
- FINISH:
  - score_valid=1 for one cycle, busy=0 in the same cycle; go to IDLE.
- Latency: req accepted at cycle T gives mmu_start at T+1 and the first act_valid at T+2. Total latency depends on MMU response timing only.
- Layer-0 features are passed through unmodified as signed values; only MMU results are requantized.
- Reset mid-operation returns everything to reset values immediately. The MMU shares rst_n, so both ends restart cleanly; the next req runs a full inference.
- Simultaneous events: mmu_done coincident with the last mmu_res_valid is the normal case and is handled as above.

Test Plan:
- Reset: assert rst_n=0 mid-run -> all outputs 0 asynchronously; state IDLE.
- Layer-0 feed: req with feat_in=32'h04030201 at T -> mmu_start=1 at T+1 with layer_sel=0; act_valid at T+2..T+5 with act_in=1,2,3,4; act_valid=0 at T+6.
- Requantization (MMU stub): layer-0 results 100, 5000, 0, then 16 repeated -> layer-1 act_in starts 6, 127, 0, 1; exactly 32 act_valid pulses.
- Full inference (stub): layer_sel sequence 0,1,2,3 with act_valid pulse counts 4,32,32,32; layer-3 res_out=18'd777 -> score=777 and score_valid for exactly 1 cycle; busy falls in that same cycle.
- Busy rejection: req pulses during FEED and COLLECT -> ignored; no extra mmu_start. A req in the cycle after score_valid -> new inference starts, mmu_start one cycle later.
- Reset during layer-1 FEED -> outputs cleared; a subsequent req with feat_in=32'h01010101 completes with the correct score from the stub.

Source files
------------

// File: rtl/t01_ai_mmu_sequencer.sv
// t01_ai_mmu_sequencer: drives the t01_ai MMU through one
// 4-layer inference per request, ping-ponging activations.
module t01_ai_mmu_sequencer #(
  parameter int N_FEAT   = 4,
  parameter int N_HID    = 32,
  parameter int RQ_SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [31:0] feat_in,
  output logic        busy,
  output logic        score_valid,
  output logic [17:0] score,
  output logic        mmu_start,
  output logic [1:0]  mmu_layer_sel,
  output logic        mmu_act_valid,
  output logic [7:0]  mmu_act_in,
  input  logic        mmu_res_valid,
  input  logic [17:0] mmu_res_out,
  input  logic        mmu_done
);

  localparam int IW = $clog2(N_HID);
  localparam int FW = $clog2(N_FEAT);
  localparam logic [IW-1:0] FEAT_LAST = IW'(N_FEAT - 1);
  localparam logic [IW-1:0] HID_LAST  = IW'(N_HID - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FEED,
    S_COLLECT,
    S_FINISH
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [1:0]          layer_q;
  logic                bank_q;
  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       res_q;
  logic [8*N_FEAT-1:0] feat_q;
  logic [17:0]         score_q;
  logic [7:0]          mem_q [2][N_HID];

  logic [IW-1:0]       last_idx;
  logic [7:0]          feat_byte;
  logic [7:0]          bank_byte;
  logic [17:0]         shifted;
  logic [7:0]          rq_byte;

  assign last_idx  = (layer_q == 2'd0) ? FEAT_LAST : HID_LAST;
  assign feat_byte = feat_q[{idx_q[FW-1:0], 3'b000} +: 8];
  assign bank_byte = mem_q[bank_q][idx_q];
  assign shifted   = mmu_res_out >> RQ_SHIFT;
  assign rq_byte   = (shifted > 18'd127) ? 8'd127 : shifted[7:0];

  assign mmu_layer_sel = layer_q;
  assign score         = score_q;

  // control state, counters, feature latch and final score
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      layer_q <= 2'd0;
      bank_q  <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      feat_q  <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            feat_q  <= feat_in[8*N_FEAT-1:0];
            layer_q <= 2'd0;
            bank_q  <= 1'b0;
          end
        end
        S_START: begin
          idx_q <= '0;
          res_q <= '0;
        end
        S_FEED: begin
          idx_q <= idx_q + IW'(1);
        end
        S_COLLECT: begin
          if (mmu_res_valid)
            res_q <= res_q + IW'(1);
          if (mmu_done) begin
            if (layer_q != 2'd3) begin
              layer_q <= layer_q + 2'd1;
              bank_q  <= ~bank_q;
            end else begin
              score_q <= mmu_res_out;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // requantized results land in the bank not being read
  always_ff @(posedge clk) begin
    if (state_q == S_COLLECT && mmu_res_valid)
      mem_q[~bank_q][res_q] <= rq_byte;
  end

  // next state, handshake outputs and activation mux
  always_comb begin
    state_d       = state_q;
    busy          = 1'b0;
    score_valid   = 1'b0;
    mmu_start     = 1'b0;
    mmu_act_valid = 1'b0;
    mmu_act_in    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req)
          state_d = S_START;
      end
      S_START: begin
        busy      = 1'b1;
        mmu_start = 1'b1;
        state_d   = S_FEED;
      end
      S_FEED: begin
        busy          = 1'b1;
        mmu_act_valid = 1'b1;
        if (idx_q == last_idx)
          state_d = S_COLLECT;
      end
      S_COLLECT: begin
        busy = 1'b1;
        if (mmu_done)
          state_d = (layer_q == 2'd3) ? S_FINISH : S_START;
      end
      S_FINISH: begin
        score_valid = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    unique case (1'b1)
      (state_q == S_FEED) && (layer_q == 2'd0):
        mmu_act_in = feat_byte;
      (state_q == S_FEED) && (layer_q != 2'd0):
        mmu_act_in = bank_byte;
      default:
        mmu_act_in = '0;
    endcase
  end

endmodule

// File: tb/tb_t01_ai_mmu_sequencer.sv
// tb_t01_ai_mmu_sequencer: MMU stub plus scoreboard
// for the inference sequencer.
module tb_t01_ai_mmu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] feat_in;
  logic        busy;
  logic        score_valid;
  logic [17:0] score;
  logic        mmu_start;
  logic [1:0]  mmu_layer_sel;
  logic        mmu_act_valid;
  logic [7:0]  mmu_act_in;
  logic        mmu_res_valid;
  logic [17:0] mmu_res_out;
  logic        mmu_done;

  t01_ai_mmu_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .feat_in       (feat_in),
    .busy          (busy),
    .score_valid   (score_valid),
    .score         (score),
    .mmu_start     (mmu_start),
    .mmu_layer_sel (mmu_layer_sel),
    .mmu_act_valid (mmu_act_valid),
    .mmu_act_in    (mmu_act_in),
    .mmu_res_valid (mmu_res_valid),
    .mmu_res_out   (mmu_res_out),
    .mmu_done      (mmu_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  act_exp   [$];
  logic [17:0] score_exp [$];
  logic [1:0]  sel_exp   [$];
  logic [17:0] forced    [$];
  logic [17:0] held_score;
  logic        prev_sv;

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] rq_ref(input logic [17:0] v);
    int q;
    q = int'(v) / 16;
    if (q > 127) q = 127;
    return 8'(q);
  endfunction

  function automatic logic [17:0] gen_val();
    logic [17:0] e [4];
    e[0] = 18'd2031; e[1] = 18'd2032;
    e[2] = 18'd2047; e[3] = 18'd2048;
    case ($urandom_range(0, 3))
      0: return 18'($urandom_range(0, 15));
      1: return 18'($urandom_range(0, 2047));
      2: return 18'($urandom);
      default: return e[$urandom_range(0, 3)];
    endcase
  endfunction

  // behavioural MMU: counts activations, returns results
  int st, cur_layer, act_cnt, res_left, gap;
  always @(negedge clk) begin
    logic [17:0] v;
    if (!rst_n) begin
      st = 0;
      mmu_res_valid = 1'b0;
      mmu_done = 1'b0;
      mmu_res_out = '0;
    end else begin
      mmu_res_valid = 1'b0;
      mmu_done = 1'b0;
      if (mmu_start) chk("stub_idle_at_start", 32'(st), 0);
      case (st)
        0: if (mmu_start) begin
          chk("sel_pending", 32'(sel_exp.size() > 0), 1);
          if (sel_exp.size() > 0)
            chk("layer_sel", 32'(mmu_layer_sel),
                32'(sel_exp.pop_front()));
          cur_layer = int'(mmu_layer_sel);
          act_cnt = 0;
          st = 1;
          mmu_res_valid = 1'($urandom_range(0, 1));
          mmu_done = 1'($urandom_range(0, 1));
          mmu_res_out = 18'($urandom);
        end
        1: if (mmu_act_valid) act_cnt++;
        else begin
          chk("act_count", 32'(act_cnt), (cur_layer == 0) ? 4 : 32);
          res_left = (cur_layer == 3) ? 1 : 32;
          gap = $urandom_range(0, 3);
          st = 2;
        end
        default: if (gap > 0) gap--;
        else begin
          v = (forced.size() > 0) ? forced.pop_front() : gen_val();
          mmu_res_out = v;
          mmu_res_valid = 1'b1;
          res_left--;
          if (cur_layer < 3) act_exp.push_back(rq_ref(v));
          else score_exp.push_back(v);
          if (res_left == 0) begin
            chk("sel_stable", 32'(mmu_layer_sel), 32'(cur_layer));
            mmu_done = 1'b1;
            st = 0;
          end else begin
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
          end
        end
      endcase
    end
  end

  // scoreboard monitor: activations and scores
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sv = 1'b0;
      held_score = '0;
    end else begin
      if (mmu_act_valid) begin
        chk("act_pending", 32'(act_exp.size() > 0), 1);
        if (act_exp.size() > 0)
          chk("act_in", 32'(mmu_act_in), 32'(act_exp.pop_front()));
      end
      if (prev_sv) chk("sv_one_cycle", 32'(score_valid), 0);
      if (score_valid) begin
        chk("busy_low_at_sv", 32'(busy), 0);
        chk("score_pending", 32'(score_exp.size() > 0), 1);
        if (score_exp.size() > 0) begin
          held_score = score_exp.pop_front();
          chk("score", 32'(score), 32'(held_score));
        end
      end
      prev_sv = score_valid;
    end
  end

  task automatic issue(input logic [31:0] f, input bit poke);
    chk("score_hold", 32'(score), 32'(held_score));
    chk("idle_busy", 32'(busy), 0);
    req = 1'b1;
    feat_in = f;
    for (int k = 0; k < 4; k++) act_exp.push_back(f[8*k +: 8]);
    for (int l = 0; l < 4; l++) sel_exp.push_back(2'(l));
    @(negedge clk);
    req = 1'b0;
    feat_in = $urandom;
    chk("start_pulse", 32'(mmu_start), 1);
    chk("busy_rise", 32'(busy), 1);
    chk("no_act_at_start", 32'(mmu_act_valid), 0);
    @(negedge clk);
    chk("start_one_cycle", 32'(mmu_start), 0);
    for (int k = 0; k < 4; k++) begin
      chk("feed_valid", 32'(mmu_act_valid), 1);
      req = poke && (k == 1);
      @(negedge clk);
    end
    req = 1'b0;
    chk("feed_end", 32'(mmu_act_valid), 0);
    if (poke) begin
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!score_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_time", 32'(score_valid), 1);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_sv"}, 32'(score_valid), 0);
    chk({tag, "_score"}, 32'(score), 0);
    chk({tag, "_start"}, 32'(mmu_start), 0);
    chk({tag, "_sel"}, 32'(mmu_layer_sel), 0);
    chk({tag, "_actv"}, 32'(mmu_act_valid), 0);
    chk({tag, "_act"}, 32'(mmu_act_in), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    req = 1'b0;
    feat_in = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;
    @(negedge clk);

    forced.push_back(18'd100);
    forced.push_back(18'd5000);
    forced.push_back(18'd0);
    repeat (29) forced.push_back(18'd16);
    repeat (64) forced.push_back(18'($urandom_range(0, 8191)));
    forced.push_back(18'd777);
    issue(32'h04030201, 1'b1);
    wait_done();
    chk("score_777", 32'(score), 777);

    req = 1'b1;
    feat_in = 32'h11223344;
    @(negedge clk);
    chk("finish_ignores_req", 32'(mmu_start), 0);
    issue(32'h11223344, 1'b0);
    wait_done();

    for (int t = 0; t < 5; t++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      issue($urandom, 1'($urandom_range(0, 1)));
      wait_done();
    end

    @(negedge clk);
    issue($urandom, 1'b0);
    n = 0;
    while (!(mmu_act_valid && mmu_layer_sel == 2'd1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_l1_feed", 32'(mmu_act_valid && mmu_layer_sel == 2'd1), 1);
    repeat ($urandom_range(0, 20)) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_cleared("midrst");
    act_exp.delete();
    score_exp.delete();
    sel_exp.delete();
    forced.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(32'h01010101, 1'b0);
    wait_done();

    repeat (3) @(negedge clk);
    chk("act_q_empty", 32'(act_exp.size()), 0);
    chk("score_q_empty", 32'(score_exp.size()), 0);
    chk("sel_q_empty", 32'(sel_exp.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
